send_scheduler: RTL

- Sequences the IR/serial Sender for the battleship link and shares it between two requesters: the response path (hit/miss reply to the opponent) and the shot path (our firing message).
- Grants one requester at a time and drives the Sender's Send_En/Code_Control.
- Repeats each message a fixed number of times for loss tolerance, enforces an inter-frame gap, and runs a watchdog on Send_Done.
- Sits between the game FSM and the Sender.

---
 rtl/send_scheduler_pkg.sv | 35 +++
 rtl/send_scheduler_if.sv | 31 +++
 rtl/send_arbiter.sv | 48 ++++
 rtl/send_scheduler.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/send_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// send_scheduler_pkg
//   Shared types and default constants for the battleship link send scheduler.
//   - state_t  : scheduler FSM encoding (IDLE, SEND, GAP)
//   - req_id_t : requester identity (RESP = response path, SHOT = shot path)
//   - DEFAULT_* : default timing constants for a 27 MHz clock, 27 cycles/bit,
//                 36-bit frames
//   - rep_dec  : saturating decrement used by the repeat counter
// -----------------------------------------------------------------------------
package send_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef enum logic {
        RESP = 1'b0,
        SHOT = 1'b1
    } req_id_t;

    localparam int BIT_CYCLES             = 27;
    localparam int FRAME_BITS             = 36;
    localparam int DEFAULT_FRAME_CYCLES   = BIT_CYCLES * FRAME_BITS;
    localparam int DEFAULT_GAP_CYCLES     = DEFAULT_FRAME_CYCLES;
    localparam int DEFAULT_REPEATS        = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // Repeat counter never wraps below zero.
    function automatic logic [3:0] rep_dec(input logic [3:0] cnt);
        return (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    endfunction

endpackage

// File: rtl/send_scheduler_if.sv
// -----------------------------------------------------------------------------
// send_scheduler_if
//   Bundles the requester handshakes (game FSM side) and the Sender controls.
//   master : the scheduler (drives acks, Send_En, Code_Control, Busy, Fault)
//   slave  : the environment (drives requests, codes and Send_Done)
// -----------------------------------------------------------------------------
interface send_scheduler_if;

    logic Resp_Req;
    logic Resp_Code;
    logic Shot_Req;
    logic Shot_Code;
    logic Resp_Ack;
    logic Shot_Ack;
    logic Send_En;
    logic Code_Control;
    logic Send_Done;
    logic Busy;
    logic Fault;

    modport master (
        input  Resp_Req, Resp_Code, Shot_Req, Shot_Code, Send_Done,
        output Resp_Ack, Shot_Ack, Send_En, Code_Control, Busy, Fault
    );

    modport slave (
        output Resp_Req, Resp_Code, Shot_Req, Shot_Code, Send_Done,
        input  Resp_Ack, Shot_Ack, Send_En, Code_Control, Busy, Fault
    );

endinterface

// File: rtl/send_arbiter.sv
// -----------------------------------------------------------------------------
// send_arbiter
//   Two-way round-robin grant between the response and shot requesters.
//   Ports:
//     Clock, Reset : clock, asynchronous active-high reset
//     arb_en       : scheduler is idle and may take a new grant this cycle
//     resp_req     : response request level
//     shot_req     : shot request level
//     grant_valid  : a grant is issued this cycle (combinational)
//     grant_id     : which requester is granted (combinational)
//   rr_ptr only moves on a tie, so a lone requester never disturbs fairness.
// -----------------------------------------------------------------------------
module send_arbiter
    import send_scheduler_pkg::*;
(
    input  logic    Clock,
    input  logic    Reset,
    input  logic    arb_en,
    input  logic    resp_req,
    input  logic    shot_req,
    output logic    grant_valid,
    output req_id_t grant_id
);

    req_id_t rr_ptr;
    logic    tie;

    assign tie = resp_req & shot_req;

    always_comb begin
        grant_valid = arb_en & (resp_req | shot_req);
        grant_id    = RESP;
        if (tie) begin
            grant_id = rr_ptr;
        end else if (shot_req) begin
            grant_id = SHOT;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rr_ptr <= RESP;
        end else if (arb_en && tie) begin
            rr_ptr <= (rr_ptr == RESP) ? SHOT : RESP;
        end
    end

endmodule

// File: rtl/send_scheduler.sv
// -----------------------------------------------------------------------------
// send_scheduler
//   Shares the IR/serial Sender between the response and shot paths. Each
//   granted message is sent REPEATS times, every frame is followed by
//   GAP_CYCLES idle cycles, and a watchdog aborts a frame whose Send_Done
//   never arrives (sticky Fault, no Ack, requester re-arbitrates).
//   Ports:
//     Clock, Reset : 27 MHz clock, asynchronous active-high reset
//     bus (master) : Resp/Shot Req+Code in, Resp/Shot Ack out,
//                    Send_En/Code_Control out, Send_Done in, Busy/Fault out
//   All outputs are registered.
// -----------------------------------------------------------------------------
module send_scheduler
    import send_scheduler_pkg::*;
#(
    parameter int REPEATS        = DEFAULT_REPEATS,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
    input  logic              Clock,
    input  logic              Reset,
    send_scheduler_if.master  bus
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       REP_INIT = 4'(REPEATS);

    state_t           state, state_n;
    req_id_t          grant_q, grant_n;
    logic             code_q, code_n;
    logic             send_en_q, send_en_n;
    logic             resp_ack_q, resp_ack_n;
    logic             shot_ack_q, shot_ack_n;
    logic             busy_q, busy_n;
    logic             fault_q, fault_n;
    logic [3:0]       rep_cnt, rep_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [WD_W-1:0]  wd_cnt, wd_n;

    logic             arb_valid;
    req_id_t          arb_id;

    send_arbiter u_arbiter (
        .Clock       (Clock),
        .Reset       (Reset),
        .arb_en      (state == IDLE),
        .resp_req    (bus.Resp_Req),
        .shot_req    (bus.Shot_Req),
        .grant_valid (arb_valid),
        .grant_id    (arb_id)
    );

    always_comb begin
        state_n    = state;
        grant_n    = grant_q;
        code_n     = code_q;
        send_en_n  = send_en_q;
        resp_ack_n = 1'b0;
        shot_ack_n = 1'b0;
        fault_n    = fault_q;
        rep_n      = rep_cnt;
        gap_n      = gap_cnt;
        wd_n       = wd_cnt;

        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_n   = arb_id;
                    // Code is captured once per grant; later changes wait.
                    code_n    = (arb_id == SHOT) ? bus.Shot_Code : bus.Resp_Code;
                    rep_n     = REP_INIT;
                    wd_n      = '0;
                    send_en_n = 1'b1;
                    state_n   = SEND;
                end
            end

            SEND: begin
                // Done has priority over a coincident watchdog expiry.
                if (bus.Send_Done) begin
                    send_en_n = 1'b0;
                    rep_n     = rep_dec(rep_cnt);
                    gap_n     = '0;
                    wd_n      = '0;
                    state_n   = GAP;
                    if (rep_cnt <= 4'd1) begin
                        resp_ack_n = (grant_q == RESP);
                        shot_ack_n = (grant_q == SHOT);
                    end
                end else if (wd_cnt == WD_LAST) begin
                    // Abort: no Ack, so the requester stays pending and
                    // competes again once the gap has elapsed.
                    send_en_n = 1'b0;
                    fault_n   = 1'b1;
                    rep_n     = 4'd0;
                    gap_n     = '0;
                    wd_n      = '0;
                    state_n   = GAP;
                end else begin
                    wd_n = wd_cnt + 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_n = '0;
                    if (rep_cnt != 4'd0) begin
                        send_en_n = 1'b1;
                        wd_n      = '0;
                        state_n   = SEND;
                    end else begin
                        state_n   = IDLE;
                    end
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end

            default: begin
                send_en_n = 1'b0;
                state_n   = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            grant_q    <= RESP;
            code_q     <= 1'b0;
            send_en_q  <= 1'b0;
            resp_ack_q <= 1'b0;
            shot_ack_q <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            rep_cnt    <= 4'd0;
            gap_cnt    <= '0;
            wd_cnt     <= '0;
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            code_q     <= code_n;
            send_en_q  <= send_en_n;
            resp_ack_q <= resp_ack_n;
            shot_ack_q <= shot_ack_n;
            busy_q     <= busy_n;
            fault_q    <= fault_n;
            rep_cnt    <= rep_n;
            gap_cnt    <= gap_n;
            wd_cnt     <= wd_n;
        end
    end

    assign bus.Send_En      = send_en_q;
    assign bus.Code_Control = code_q;
    assign bus.Resp_Ack     = resp_ack_q;
    assign bus.Shot_Ack     = shot_ack_q;
    assign bus.Busy         = busy_q;
    assign bus.Fault        = fault_q;

endmodule
